// File: rtl/crossy_game_ctrl.sv
// crossy_game_ctrl: game sequencer for the VGA crossy-road design.
// Synchronizes and debounces the move button on frame ticks, runs the
// IDLE/PLAY/HIT/OVER game FSM, owns the score, and pulses `advance` once per
// accepted move.
// Optional feature macro: CROSSY_HISCORE_EN. When it is defined, a best-score
// register is built. When it is undefined, `hiscore` is tied to zero.
module crossy_game_ctrl #(
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int HIT_FRAMES      = 60,
  parameter int FLASH_SHIFT     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       move_btn,
  input  logic       collision,
  output logic       advance,
  output logic       run,
  output logic [7:0] score,
  output logic [7:0] hiscore,
  output logic [1:0] state,
  output logic       flash
);

  localparam int DW = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
  localparam int HW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
  localparam int FW = FLASH_SHIFT + 1;
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_FRAMES - 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(HIT_FRAMES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  // Input conditioning
  logic          r_sync0;
  logic          r_sync1;
  logic          r_btn_db;
  logic          r_btn_db_d;
  logic [DW-1:0] r_dcnt;
  logic          r_hit_pend;

  // Game state and registered outputs
  state_t        r_state;
  logic [HW-1:0] r_hcnt;
  logic [FW-1:0] r_fcnt;
  logic          r_advance;
  logic          r_run;
  logic [7:0]    r_score;
  logic          r_flash;

  // Combinational next values
  logic          w_press;
  logic          w_hit_now;
  state_t        w_state_nxt;
  logic [HW-1:0] w_hcnt_nxt;
  logic [FW-1:0] w_fcnt_nxt;
  logic [7:0]    w_score_nxt;
  logic          w_advance_nxt;
  logic          w_run_nxt;
  logic          w_flash_nxt;

  // A press is the single cycle after the debounced level rises; since btn_db
  // only changes on a frame tick, a press never coincides with a tick.
  assign w_press   = r_btn_db & ~r_btn_db_d;
  // Death is decided on the frame tick: either a collision latched earlier in
  // the frame or one that is present in the tick cycle itself.
  assign w_hit_now = frame_tick & (r_hit_pend | collision);

  // Two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
    end else begin
      r_sync0 <= move_btn;
      r_sync1 <= r_sync0;
    end
  end

  // Frame-rate debounce: a changed level must persist for DEBOUNCE_FRAMES ticks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
      r_dcnt     <= '0;
    end else begin
      r_btn_db_d <= r_btn_db;
      if (frame_tick) begin
        if (r_sync1 == r_btn_db) begin
          r_dcnt <= '0;
        end else if (r_dcnt == DB_LAST) begin
          r_btn_db <= r_sync1;
          r_dcnt   <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end
    end
  end

  // Sticky collision capture during PLAY, consumed by every frame tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_pend <= 1'b0;
    end else if (frame_tick) begin
      r_hit_pend <= 1'b0;
    end else if (collision && (r_state == S_PLAY)) begin
      r_hit_pend <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_press) w_state_nxt = S_PLAY;
      S_PLAY:  if (w_hit_now) w_state_nxt = S_HIT;
      S_HIT:   if (frame_tick && (r_hcnt == '0)) w_state_nxt = S_OVER;
      S_OVER:  if (w_press) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: next values for score, advance, counters and flash
  always_comb begin
    w_advance_nxt = 1'b0;
    w_score_nxt   = r_score;
    w_hcnt_nxt    = r_hcnt;
    w_fcnt_nxt    = r_fcnt;
    case (r_state)
      S_IDLE: begin
        if (w_press) w_score_nxt = 8'd0;
      end
      S_PLAY: begin
        if (w_hit_now) begin
          w_hcnt_nxt = HIT_LAST;
          w_fcnt_nxt = '0;
        end else if (w_press) begin
          w_advance_nxt = 1'b1;
          if (r_score != 8'hFF) w_score_nxt = r_score + 8'd1;
        end
      end
      S_HIT: begin
        if (frame_tick) begin
          w_fcnt_nxt = r_fcnt + 1'b1;
          if (r_hcnt != '0) w_hcnt_nxt = r_hcnt - 1'b1;
        end
      end
      default: ;
    endcase
    w_run_nxt   = (w_state_nxt == S_PLAY);
    w_flash_nxt = (w_state_nxt == S_HIT) ? w_fcnt_nxt[FLASH_SHIFT] : 1'b0;
  end

  // Registered outputs and HIT counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_advance <= 1'b0;
      r_run     <= 1'b0;
      r_score   <= 8'd0;
      r_flash   <= 1'b0;
      r_hcnt    <= '0;
      r_fcnt    <= '0;
    end else begin
      r_advance <= w_advance_nxt;
      r_run     <= w_run_nxt;
      r_score   <= w_score_nxt;
      r_flash   <= w_flash_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_fcnt    <= w_fcnt_nxt;
    end
  end

`ifdef CROSSY_HISCORE_EN
  logic [7:0] r_hiscore;

  // Best score is folded in on the edge that enters OVER; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hiscore <= 8'd0;
    end else if ((r_state == S_HIT) && (w_state_nxt == S_OVER) && (r_score > r_hiscore)) begin
      r_hiscore <= r_score;
    end
  end

  assign hiscore = r_hiscore;
`else
  assign hiscore = 8'd0;
`endif

  assign advance = r_advance;
  assign run     = r_run;
  assign score   = r_score;
  assign state   = r_state;
  assign flash   = r_flash;

endmodule

// File: tb/tb_crossy_game_ctrl.sv
// Testbench for crossy_game_ctrl: directed scenarios plus randomized play,
// every cycle compared against a frame/event-level reference model.
module tb_crossy_game_ctrl;

  localparam int DEBOUNCE_FRAMES = 3;
  localparam int HIT_FRAMES      = 4;
  localparam int FLASH_SHIFT     = 0;
  localparam int FRAME_LEN       = 8;

  localparam int ST_IDLE = 0;
  localparam int ST_PLAY = 1;
  localparam int ST_HIT  = 2;
  localparam int ST_OVER = 3;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       move_btn;
  logic       collision;
  logic       advance;
  logic       run;
  logic [7:0] score;
  logic [7:0] hiscore;
  logic [1:0] state;
  logic       flash;

  always #5 clk = ~clk;

  crossy_game_ctrl #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
    .HIT_FRAMES     (HIT_FRAMES),
    .FLASH_SHIFT    (FLASH_SHIFT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .move_btn  (move_btn),
    .collision (collision),
    .advance   (advance),
    .run       (run),
    .score     (score),
    .hiscore   (hiscore),
    .state     (state),
    .flash     (flash)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int adv_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Game-level view: a button pipeline of two samples, a debounce streak
  // count, and a count of HIT ticks elapsed since the death.
  bit m_s1, m_s2, m_db, m_db_prev;
  int m_streak, m_state, m_score, m_hit_ticks, m_hi;
  bit m_hit_pend, m_adv, m_flash;

  task automatic model_step(input bit rst, input bit ft, input bit mb, input bit col);
    bit press;
    int old_state;
    bit old_s2;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_db_prev = 0; m_streak = 0;
      m_state = ST_IDLE; m_score = 0; m_hit_ticks = 0; m_hi = 0;
      m_hit_pend = 0; m_adv = 0; m_flash = 0;
      return;
    end
    press     = m_db && !m_db_prev;
    old_state = m_state;
    old_s2    = m_s2;
    m_adv     = 0;
    case (old_state)
      ST_IDLE: if (press) begin m_state = ST_PLAY; m_score = 0; end
      ST_PLAY: begin
        if (ft && (m_hit_pend || col)) begin
          m_state = ST_HIT;
          m_hit_ticks = 0;
        end else if (press) begin
          m_adv = 1;
          m_score = (m_score < 255) ? m_score + 1 : 255;
        end
      end
      ST_HIT: begin
        if (ft) begin
          m_hit_ticks++;
          if (m_hit_ticks == HIT_FRAMES) begin
            m_state = ST_OVER;
`ifdef CROSSY_HISCORE_EN
            if (m_score > m_hi) m_hi = m_score;
`endif
          end
        end
      end
      default: if (press) m_state = ST_IDLE;
    endcase
    if (ft) m_hit_pend = 0;
    else if (col && old_state == ST_PLAY) m_hit_pend = 1;
    m_db_prev = m_db;
    if (ft) begin
      if (old_s2 != m_db) begin
        m_streak++;
        if (m_streak == DEBOUNCE_FRAMES) begin
          m_db = old_s2;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = mb;
    m_flash = (m_state == ST_HIT) ? (((m_hit_ticks >> FLASH_SHIFT) & 1) != 0) : 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit rst, input bit ft, input bit mb, input bit col);
    reset = rst; frame_tick = ft; move_btn = mb; collision = col;
    @(posedge clk);
    model_step(rst, ft, mb, col);
    #1;
    check("state",   state,   m_state);
    check("score",   score,   m_score);
    check("advance", advance, m_adv);
    check("run",     run,     (m_state == ST_PLAY));
    check("flash",   flash,   m_flash);
    check("hiscore", hiscore, m_hi);
    if (advance === 1'b1) adv_cnt++;
  endtask

  // One frame: tick in cycle 0, button held, optional one-cycle collision
  task automatic frame(input bit mb, input int col_at);
    for (int c = 0; c < FRAME_LEN; c++) cycle(1'b0, (c == 0), mb, (c == col_at));
  endtask

  task automatic press_once();
    for (int f = 0; f < 4; f++) frame(1'b1, -1);
    for (int f = 0; f < 4; f++) frame(1'b0, -1);
  endtask

  // Collision mid-frame, then enough frames to reach OVER
  task automatic die();
    frame(1'b0, 4);
    for (int f = 0; f < HIT_FRAMES + 1; f++) frame(1'b0, -1);
  endtask

  int exp_hi;
  int adv0;

  initial begin
    reset = 1'b1; frame_tick = 1'b0; move_btn = 1'b0; collision = 1'b0;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_state", state, ST_IDLE);
    check("rst_score", score, 0);

    // Too-short hold is rejected, a full hold starts a game without advance
    adv_cnt = 0;
    for (int f = 0; f < 2; f++) frame(1'b1, -1);
    for (int f = 0; f < 4; f++) frame(1'b0, -1);
    check("short_hold_state", state, ST_IDLE);
    press_once();
    check("start_state", state, ST_PLAY);
    check("start_score", score, 0);
    check("start_no_adv", adv_cnt, 0);

    // Four clean presses
    for (int p = 0; p < 4; p++) press_once();
    check("four_adv", adv_cnt, 4);
    check("four_score", score, 4);

    // Game 1 to score 7 and a collision pulse mid-frame
    for (int p = 0; p < 3; p++) press_once();
    check("g1_score", score, 7);
    frame(1'b0, 4);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("hit_state", state, ST_HIT);
    check("hit_run", run, 0);
    for (int c = 1; c < FRAME_LEN; c++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= HIT_FRAMES; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      if (k == 1) check("flash_tick1", flash, 1);
      if (k == 2) check("flash_tick2", flash, 0);
      check("hit_len_state", state, (k < HIT_FRAMES) ? ST_HIT : ST_OVER);
      for (int c = 1; c < FRAME_LEN; c++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("over_score", score, 7);
`ifdef CROSSY_HISCORE_EN
    exp_hi = 7;
`else
    exp_hi = 0;
`endif
    check("hiscore_g1", hiscore, exp_hi);

    // Game 2 dies at 3; best stays 7
    press_once();
    check("over_to_idle", state, ST_IDLE);
    press_once();
    for (int p = 0; p < 3; p++) press_once();
    die();
    check("g2_state", state, ST_OVER);
    check("g2_score", score, 3);
    check("hiscore_g2", hiscore, exp_hi);

    // Saturation at 255
    press_once();
    press_once();
    for (int p = 0; p < 255; p++) press_once();
    check("sat_score", score, 255);
    adv0 = adv_cnt;
    press_once();
    check("sat_adv", adv_cnt - adv0, 1);
    check("sat_hold", score, 255);

    // Collision and debounced rise on the same tick
    adv0 = adv_cnt;
    for (int c = 0; c < FRAME_LEN; c++) cycle(1'b0, (c == 0), (c >= 4), 1'b0);
    frame(1'b1, -1);
    frame(1'b1, -1);
    frame(1'b1, 0);
    check("simul_state", state, ST_HIT);
    check("simul_score", score, 255);
    check("simul_adv", adv_cnt - adv0, 0);
    for (int f = 0; f < HIT_FRAMES + 4; f++) frame(1'b0, -1);
    check("simul_over", state, ST_OVER);

    // Reset mid-PLAY at score 5
    press_once();
    press_once();
    for (int p = 0; p < 5; p++) press_once();
    check("pre_rst_score", score, 5);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_rst_state", state, ST_IDLE);
    check("mid_rst_score", score, 0);
    check("mid_rst_adv", advance, 0);
    check("mid_rst_run", run, 0);
    check("mid_rst_flash", flash, 0);
    check("mid_rst_hi", hiscore, 0);

    // Randomized play
    for (int f = 0; f < 300; f++) begin
      bit lvl;
      int hold;
      lvl  = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        for (int c = 0; c < FRAME_LEN; c++) begin
          bit col, rst, mb;
          col = ($urandom_range(0, 19) == 0);
          rst = ($urandom_range(0, 999) == 0);
          mb  = ($urandom_range(0, 15) == 0) ? ~lvl : lvl;
          cycle(rst, (c == 0), mb, col);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
